// File: rtl/rs_pool.sv
// rs_pool: unified reservation-station pool with tag-based operand wakeup.
//   Dispatch writes the lowest free entry, capturing any operand that is being
//   forwarded in the same cycle. Every busy entry snoops the forwarding channels
//   and captures missing operands. The lowest-index entry with both operands
//   valid is offered for issue; it is freed when the issue handshake fires.
// Ports:
//   clk, rst_n (async, active-low)    clock and reset
//   i_flush                           synchronous kill of all entries
//   i_dp_*  / o_dp_rdy                dispatch request, operands, payload, dest tag
//   i_fwd_vld/tag/data                NUM_FWD result-forwarding channels (slice k = channel k)
//   o_iss_* / i_iss_rdy               issue handshake and selected entry fields
//   o_cnt, o_full, o_empty            occupancy
module rs_pool #(
  parameter int DEPTH     = 8,
  parameter int NUM_FWD   = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 40,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_dp_vld,
  output logic                       o_dp_rdy,
  input  logic [PAYLOAD_W-1:0]       i_dp_payload,
  input  logic [TAG_W-1:0]           i_dp_rrftag,
  input  logic                       i_dp_rs1_vld,
  input  logic                       i_dp_rs2_vld,
  input  logic [DATA_W-1:0]          i_dp_rs1,
  input  logic [DATA_W-1:0]          i_dp_rs2,
  input  logic [NUM_FWD-1:0]         i_fwd_vld,
  input  logic [NUM_FWD*TAG_W-1:0]   i_fwd_tag,
  input  logic [NUM_FWD*DATA_W-1:0]  i_fwd_data,
  output logic                       o_iss_vld,
  input  logic                       i_iss_rdy,
  output logic [PAYLOAD_W-1:0]       o_iss_payload,
  output logic [DATA_W-1:0]          o_iss_rs1,
  output logic [DATA_W-1:0]          o_iss_rs2,
  output logic [TAG_W-1:0]           o_iss_rrftag,
  output logic [IDX_W-1:0]           o_iss_idx,
  output logic [CNT_W-1:0]           o_cnt,
  output logic                       o_full,
  output logic                       o_empty
);

  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     rs1_vld;
  logic [DEPTH-1:0]     rs2_vld;
  logic [DATA_W-1:0]    rs1_val [DEPTH];
  logic [DATA_W-1:0]    rs2_val [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  logic [TAG_W-1:0]     rrftag  [DEPTH];

  // True when any active channel broadcasts the given tag.
  function automatic logic fwd_hit(input logic [TAG_W-1:0] tag);
    fwd_hit = 1'b0;
    for (int k = 0; k < NUM_FWD; k++)
      if (i_fwd_vld[k] && (i_fwd_tag[k*TAG_W +: TAG_W] == tag)) fwd_hit = 1'b1;
  endfunction

  // Data of the matching channel; scanning downward lets the lowest index win.
  function automatic logic [DATA_W-1:0] fwd_data(input logic [TAG_W-1:0] tag);
    fwd_data = '0;
    for (int k = NUM_FWD-1; k >= 0; k--)
      if (i_fwd_vld[k] && (i_fwd_tag[k*TAG_W +: TAG_W] == tag))
        fwd_data = i_fwd_data[k*DATA_W +: DATA_W];
  endfunction

  logic [DEPTH-1:0]  wk1_hit, wk2_hit, ready;
  logic [DATA_W-1:0] wk1_dat [DEPTH];
  logic [DATA_W-1:0] wk2_dat [DEPTH];
  logic              dp1_hit, dp2_hit;
  logic [DATA_W-1:0] dp1_dat, dp2_dat;
  logic [IDX_W-1:0]  free_idx, sel_idx;
  logic              any_rdy, dp_acc, iss_fire;

  // Operand snooping: a waiting operand holds its producer tag in the low bits.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1_hit[i] = fwd_hit(rs1_val[i][TAG_W-1:0]);
      wk1_dat[i] = fwd_data(rs1_val[i][TAG_W-1:0]);
      wk2_hit[i] = fwd_hit(rs2_val[i][TAG_W-1:0]);
      wk2_dat[i] = fwd_data(rs2_val[i][TAG_W-1:0]);
    end
    dp1_hit = fwd_hit(i_dp_rs1[TAG_W-1:0]);
    dp1_dat = fwd_data(i_dp_rs1[TAG_W-1:0]);
    dp2_hit = fwd_hit(i_dp_rs2[TAG_W-1:0]);
    dp2_dat = fwd_data(i_dp_rs2[TAG_W-1:0]);
  end

  // Selection, occupancy and issue outputs, all derived from registered state.
  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    any_rdy  = 1'b0;
    o_cnt    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      ready[i] = busy[i] && rs1_vld[i] && rs2_vld[i];
      if (!busy[i]) free_idx = IDX_W'(i);
      if (ready[i]) begin
        sel_idx = IDX_W'(i);
        any_rdy = 1'b1;
      end
      o_cnt = o_cnt + CNT_W'(busy[i]);
    end
    o_full   = (o_cnt == CNT_W'(DEPTH));
    o_empty  = (o_cnt == '0);
    o_dp_rdy = !o_full;
    dp_acc   = i_dp_vld && o_dp_rdy && !i_flush;

    o_iss_vld     = any_rdy && !i_flush;
    iss_fire      = o_iss_vld && i_iss_rdy;
    o_iss_payload = '0;
    o_iss_rs1     = '0;
    o_iss_rs2     = '0;
    o_iss_rrftag  = '0;
    o_iss_idx     = '0;
    if (o_iss_vld) begin
      o_iss_payload = payload[sel_idx];
      o_iss_rs1     = rs1_val[sel_idx];
      o_iss_rs2     = rs2_val[sel_idx];
      o_iss_rrftag  = rrftag[sel_idx];
      o_iss_idx     = sel_idx;
    end
  end

  // Entry state update: wakeup, issue release and dispatch write.
  // Dispatch always targets a non-busy entry, so it never collides with
  // wakeup or issue of the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= '0;
      rs1_vld <= '0;
      rs2_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_val[i] <= '0;
        rs2_val[i] <= '0;
        payload[i] <= '0;
        rrftag[i]  <= '0;
      end
    end else if (i_flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && !rs1_vld[i] && wk1_hit[i]) begin
          rs1_val[i] <= wk1_dat[i];
          rs1_vld[i] <= 1'b1;
        end
        if (busy[i] && !rs2_vld[i] && wk2_hit[i]) begin
          rs2_val[i] <= wk2_dat[i];
          rs2_vld[i] <= 1'b1;
        end
      end
      if (iss_fire) busy[sel_idx] <= 1'b0;
      if (dp_acc) begin
        busy[free_idx]    <= 1'b1;
        payload[free_idx] <= i_dp_payload;
        rrftag[free_idx]  <= i_dp_rrftag;
        rs1_vld[free_idx] <= i_dp_rs1_vld || dp1_hit;
        rs2_vld[free_idx] <= i_dp_rs2_vld || dp2_hit;
        rs1_val[free_idx] <= (!i_dp_rs1_vld && dp1_hit) ? dp1_dat : i_dp_rs1;
        rs2_val[free_idx] <= (!i_dp_rs2_vld && dp2_hit) ? dp2_dat : i_dp_rs2;
      end
    end
  end

endmodule

// File: tb/tb_rs_pool.sv
// tb_rs_pool: directed, table-driven bench for rs_pool with default parameters
// (DEPTH=8, NUM_FWD=4, DATA_W=32, TAG_W=6, PAYLOAD_W=40).
module tb_rs_pool;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_flush;
  logic         i_dp_vld;
  logic         o_dp_rdy;
  logic [39:0]  i_dp_payload;
  logic [5:0]   i_dp_rrftag;
  logic         i_dp_rs1_vld, i_dp_rs2_vld;
  logic [31:0]  i_dp_rs1, i_dp_rs2;
  logic [3:0]   i_fwd_vld;
  logic [23:0]  i_fwd_tag;
  logic [127:0] i_fwd_data;
  logic         o_iss_vld;
  logic         i_iss_rdy;
  logic [39:0]  o_iss_payload;
  logic [31:0]  o_iss_rs1, o_iss_rs2;
  logic [5:0]   o_iss_rrftag;
  logic [2:0]   o_iss_idx;
  logic [3:0]   o_cnt;
  logic         o_full, o_empty;

  int checks = 0;
  int errors = 0;

  rs_pool dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_dp_vld(i_dp_vld), .o_dp_rdy(o_dp_rdy),
    .i_dp_payload(i_dp_payload), .i_dp_rrftag(i_dp_rrftag),
    .i_dp_rs1_vld(i_dp_rs1_vld), .i_dp_rs2_vld(i_dp_rs2_vld),
    .i_dp_rs1(i_dp_rs1), .i_dp_rs2(i_dp_rs2),
    .i_fwd_vld(i_fwd_vld), .i_fwd_tag(i_fwd_tag), .i_fwd_data(i_fwd_data),
    .o_iss_vld(o_iss_vld), .i_iss_rdy(i_iss_rdy),
    .o_iss_payload(o_iss_payload), .o_iss_rs1(o_iss_rs1), .o_iss_rs2(o_iss_rs2),
    .o_iss_rrftag(o_iss_rrftag), .o_iss_idx(o_iss_idx),
    .o_cnt(o_cnt), .o_full(o_full), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;   logic        r1v;  logic [31:0] r1;
    logic        r2v;  logic [31:0] r2;   logic [5:0]  tag;  logic [39:0] pl;
    logic        fv;   int          fch;  logic [5:0]  ftag; logic [31:0] fdat;
    logic        ir;   logic        fl;
    logic        ev;   logic [31:0] e1;   logic [31:0] e2;   logic [5:0]  etag;
    logic [2:0]  eidx; logic [39:0] epl;  logic [3:0]  ecnt; logic        erdy;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    i_flush = 1'b0; i_dp_vld = 1'b0; i_dp_payload = '0; i_dp_rrftag = '0;
    i_dp_rs1_vld = 1'b0; i_dp_rs2_vld = 1'b0; i_dp_rs1 = '0; i_dp_rs2 = '0;
    i_fwd_vld = '0; i_fwd_tag = '0; i_fwd_data = '0; i_iss_rdy = 1'b0;
  endtask

  task automatic dispatch(input logic r1v, input logic [31:0] r1, input logic r2v,
                          input logic [31:0] r2, input logic [5:0] tag, input logic [39:0] pl);
    i_dp_vld = 1'b1; i_dp_rs1_vld = r1v; i_dp_rs1 = r1; i_dp_rs2_vld = r2v; i_dp_rs2 = r2;
    i_dp_rrftag = tag; i_dp_payload = pl;
  endtask

  task automatic fwd(input int ch, input logic [5:0] tag, input logic [31:0] data);
    i_fwd_vld[ch] = 1'b1;
    i_fwd_tag[ch*6 +: 6] = tag;
    i_fwd_data[ch*32 +: 32] = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int n);
    string s;
    idle();
    if (v.dv) dispatch(v.r1v, v.r1, v.r2v, v.r2, v.tag, v.pl);
    if (v.fv) fwd(v.fch, v.ftag, v.fdat);
    i_iss_rdy = v.ir;
    i_flush = v.fl;
    @(negedge clk);
    s = $sformatf("v%0d", n);
    chk({s, ".iss_vld"}, 64'(o_iss_vld), 64'(v.ev));
    chk({s, ".rs1"}, 64'(o_iss_rs1), 64'(v.e1));
    chk({s, ".rs2"}, 64'(o_iss_rs2), 64'(v.e2));
    chk({s, ".rrftag"}, 64'(o_iss_rrftag), 64'(v.etag));
    chk({s, ".idx"}, 64'(o_iss_idx), 64'(v.eidx));
    chk({s, ".payload"}, 64'(o_iss_payload), 64'(v.epl));
    chk({s, ".cnt"}, 64'(o_cnt), 64'(v.ecnt));
    chk({s, ".dp_rdy"}, 64'(o_dp_rdy), 64'(v.erdy));
    chk({s, ".empty"}, 64'(o_empty), 64'(v.ecnt == 4'd0));
    chk({s, ".full"}, 64'(o_full), 64'(v.ecnt == 4'd8));
    tick();
  endtask

  initial begin
    // dv r1v r1 r2v r2 tag pl | fv fch ftag fdat | ir fl | ev e1 e2 etag eidx epl ecnt erdy
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 32'h5,  1'b1, 32'h7,  6'd3, 40'h100, 1'b0, 0, 6'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b1, 1'b0, 1'b1, 32'h5,    32'h7,    6'd3, 3'd0, 40'h100, 4'd1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'h22, 1'b0, 32'h9,  6'd5, 40'h200, 1'b0, 0, 6'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b1, 2, 6'd9,  32'hDEAD, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b1, 1'b0, 1'b1, 32'h22,   32'hDEAD, 6'd5, 3'd0, 40'h200, 4'd1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h4,  1'b1, 32'h33, 6'd7, 40'h300, 1'b1, 0, 6'd4,  32'h11,   1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b1, 1'b0, 1'b1, 32'h11,   32'h33,   6'd7, 3'd0, 40'h300, 4'd1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b1, 1, 6'd4,  32'h99,   1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 32'hA,  1'b1, 32'h1,  6'd8, 40'h400, 1'b1, 1, 6'd11, 32'hBAD,  1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b1, 3, 6'd12, 32'hBAD,  1'b1, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b1, 1, 6'd10, 32'h1010, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b1, 1'b0, 1'b1, 32'h1010, 32'h1,    6'd8, 3'd0, 40'h400, 4'd1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  6'd0, 40'h0,   1'b0, 0, 6'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    6'd0, 3'd0, 40'h0,   4'd0, 1'b1};

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst.iss_vld", 64'(o_iss_vld), 64'd0);
    chk("rst.dp_rdy", 64'(o_dp_rdy), 64'd1);
    chk("rst.cnt", 64'(o_cnt), 64'd0);
    chk("rst.empty", 64'(o_empty), 64'd1);
    chk("rst.full", 64'(o_full), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 18; n++) apply_vec(vecs[n], n);

    // Fill to DEPTH, overflow dispatch, free one entry and refill it.
    for (int i = 0; i < 8; i++) begin
      idle();
      dispatch(1'b1, 32'(100 + i), 1'b1, 32'(200 + i), 6'(i), 40'(i));
      tick();
    end
    idle();
    @(negedge clk);
    chk("full.cnt", 64'(o_cnt), 64'd8);
    chk("full.full", 64'(o_full), 64'd1);
    chk("full.dp_rdy", 64'(o_dp_rdy), 64'd0);
    chk("full.idx", 64'(o_iss_idx), 64'd0);
    tick();
    dispatch(1'b1, 32'h999, 1'b1, 32'h999, 6'd40, 40'hEEE);
    tick();
    idle();
    @(negedge clk);
    chk("ovf.cnt", 64'(o_cnt), 64'd8);
    tick();
    i_iss_rdy = 1'b1;
    dispatch(1'b1, 32'h77, 1'b1, 32'h77, 6'd41, 40'h77);
    @(negedge clk);
    chk("iss_full.dp_rdy", 64'(o_dp_rdy), 64'd0);
    chk("iss_full.rs1", 64'(o_iss_rs1), 64'd100);
    tick();
    idle();
    @(negedge clk);
    chk("freed.cnt", 64'(o_cnt), 64'd7);
    chk("freed.dp_rdy", 64'(o_dp_rdy), 64'd1);
    chk("freed.idx", 64'(o_iss_idx), 64'd1);
    tick();
    dispatch(1'b1, 32'h55, 1'b1, 32'h66, 6'd20, 40'h55);
    tick();
    idle();
    @(negedge clk);
    chk("refill.cnt", 64'(o_cnt), 64'd8);
    chk("refill.idx", 64'(o_iss_idx), 64'd0);
    chk("refill.rs1", 64'(o_iss_rs1), 64'h55);
    chk("refill.tag", 64'(o_iss_rrftag), 64'd20);
    tick();
    i_iss_rdy = 1'b1;
    tick();
    // Dispatch and issue in the same cycle keep the count steady.
    dispatch(1'b1, 32'h88, 1'b1, 32'h89, 6'd21, 40'h88);
    i_iss_rdy = 1'b1;
    @(negedge clk);
    chk("both.idx", 64'(o_iss_idx), 64'd1);
    chk("both.cnt_before", 64'(o_cnt), 64'd7);
    tick();
    idle();
    @(negedge clk);
    chk("both.cnt_after", 64'(o_cnt), 64'd7);
    chk("both.idx_after", 64'(o_iss_idx), 64'd0);
    chk("both.rs1_after", 64'(o_iss_rs1), 64'h88);
    tick();
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush1.iss_vld", 64'(o_iss_vld), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("flush1.cnt", 64'(o_cnt), 64'd0);
    tick();

    // Priority among ready entries, lowest-channel win, valid operands untouched.
    dispatch(1'b0, 32'd30, 1'b1, 32'h2, 6'd10, 40'hA0);  tick();
    dispatch(1'b1, 32'd30, 1'b1, 32'h12, 6'd11, 40'hA1); tick();
    dispatch(1'b1, 32'h3, 1'b0, 32'd31, 6'd12, 40'hA2);  tick();
    dispatch(1'b1, 32'h4, 1'b1, 32'h5, 6'd13, 40'hA3);   tick();
    idle();
    @(negedge clk);
    chk("prio.idx", 64'(o_iss_idx), 64'd1);
    chk("prio.tag", 64'(o_iss_rrftag), 64'd11);
    chk("prio.cnt", 64'(o_cnt), 64'd4);
    tick();
    fwd(3, 6'd30, 32'hA3);
    fwd(1, 6'd30, 32'hA1);
    fwd(2, 6'd31, 32'hB2);
    tick();
    idle();
    @(negedge clk);
    chk("lowch.idx", 64'(o_iss_idx), 64'd0);
    chk("lowch.rs1", 64'(o_iss_rs1), 64'hA1);
    tick();
    i_iss_rdy = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("keep.idx", 64'(o_iss_idx), 64'd1);
    chk("keep.rs1", 64'(o_iss_rs1), 64'd30);
    tick();
    i_iss_rdy = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("wake2.idx", 64'(o_iss_idx), 64'd2);
    chk("wake2.rs2", 64'(o_iss_rs2), 64'hB2);
    tick();
    i_flush = 1'b1;
    i_iss_rdy = 1'b1;
    dispatch(1'b1, 32'h1, 1'b1, 32'h2, 6'd14, 40'hA4);
    @(negedge clk);
    chk("flush2.iss_vld", 64'(o_iss_vld), 64'd0);
    chk("flush2.rs2", 64'(o_iss_rs2), 64'd0);
    chk("flush2.idx", 64'(o_iss_idx), 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("flush2.cnt", 64'(o_cnt), 64'd0);
    chk("flush2.empty", 64'(o_empty), 64'd1);
    chk("flush2.iss_vld_after", 64'(o_iss_vld), 64'd0);
    tick();

    // Asynchronous reset in the middle of a cycle with five entries busy.
    for (int i = 0; i < 5; i++) begin
      idle();
      dispatch(1'b1, 32'(i + 1), 1'b1, 32'(i + 2), 6'(i), 40'(i));
      tick();
    end
    idle();
    @(negedge clk);
    chk("pre_rst.cnt", 64'(o_cnt), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.iss_vld", 64'(o_iss_vld), 64'd0);
    chk("arst.cnt", 64'(o_cnt), 64'd0);
    chk("arst.dp_rdy", 64'(o_dp_rdy), 64'd1);
    chk("arst.empty", 64'(o_empty), 64'd1);
    chk("arst.full", 64'(o_full), 64'd0);
    chk("arst.rs1", 64'(o_iss_rs1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst.cnt", 64'(o_cnt), 64'd0);
    chk("post_rst.iss_vld", 64'(o_iss_vld), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_pool.md
RS_POOL -- requirements
Module: rs_pool

Interface
REQ-001 Parameter DEPTH, default 8, number of reservation-station entries (power of two, >=2).
REQ-002 Parameter NUM_FWD, default 4, number of result-forwarding channels.
REQ-003 Parameter DATA_W, default 32, operand/result width; TAG_W, default 6, rename-buffer tag width (TAG_W <= DATA_W).
REQ-004 Parameter PAYLOAD_W, default 40, opaque per-entry payload width (op selects, pc, imm) carried unmodified.
REQ-005 clk  in  1  clock; sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 i_flush  in  1  synchronous kill of all entries.
REQ-008 i_dp_vld  in  1  dispatch request; o_dp_rdy  out  1  a free entry exists.
REQ-009 i_dp_payload  in  PAYLOAD_W; i_dp_rrftag  in  TAG_W  destination tag.
REQ-010 i_dp_rs1_vld, i_dp_rs2_vld  in  1 each  operand ready; i_dp_rs1, i_dp_rs2  in  DATA_W each  value if ready, else producer tag in bits [TAG_W-1:0].
REQ-011 i_fwd_vld  in  NUM_FWD; i_fwd_tag  in  NUM_FWD*TAG_W; i_fwd_data  in  NUM_FWD*DATA_W  channel k at slice k.
REQ-012 o_iss_vld  out  1; i_iss_rdy  in  1  issue handshake.
REQ-013 o_iss_payload  out  PAYLOAD_W; o_iss_rs1, o_iss_rs2  out  DATA_W; o_iss_rrftag  out  TAG_W; o_iss_idx  out  log2(DEPTH).
REQ-014 o_cnt  out  log2(DEPTH)+1  occupied entries; o_full, o_empty  out  1.

Function
REQ-015 Per entry state: busy, rs1_vld, rs2_vld, rs1, rs2, payload, rrftag; all registered.
REQ-016 o_dp_rdy = !o_full, from registered busy only; dispatch accepted when i_dp_vld && o_dp_rdy && !i_flush, else ignored without state change.
REQ-017 Accepted dispatch writes lowest-index non-busy entry at the edge; busy=1.
REQ-018 Dispatch-cycle capture: if i_dp_rsN_vld=0 and tag matches an active fwd channel in the same cycle, entry stores that channel's data with rsN_vld=1.
REQ-019 Wakeup: every busy entry with rsN_vld=0 whose tag matches an active channel captures data and sets rsN_vld=1 at the edge.
REQ-020 Multiple channels matching one tag: lowest channel index wins.
REQ-021 Entry ready = busy && rs1_vld && rs2_vld, registered state only; wakeup/dispatch at edge T makes entry issuable at T+1 earliest.
REQ-022 o_iss_vld = any entry ready && !i_flush; selected entry = lowest-index ready; o_iss_* present its fields combinationally; all zero when o_iss_vld=0.
REQ-023 Issue fires when o_iss_vld && i_iss_rdy; selected entry busy cleared at edge; no other field cleared.
REQ-024 Freed entry not reusable same cycle; o_dp_rdy reflects it next cycle.
REQ-025 Simultaneous dispatch and issue: both take effect; o_cnt unchanged.
REQ-026 o_cnt = popcount(busy); o_full = (o_cnt==DEPTH); o_empty = (o_cnt==0).
REQ-027 i_flush=1: all busy cleared at edge, o_iss_vld=0 that cycle, dispatch that cycle dropped.
REQ-028 Wakeup on entry not busy or already valid operand: no effect.
REQ-029 Stale fields of non-busy entries never affect outputs.

Reset
REQ-030 rst_n low asynchronously clears all busy, rs1_vld, rs2_vld, and zeroes rs1, rs2, payload, rrftag.
REQ-031 During/after reset: o_iss_vld=0, o_dp_rdy=1, o_cnt=0, o_empty=1, o_full=0; reset mid-operation discards all entries.

Verification
REQ-032 Dispatch rs1=5 (vld), rs2=7 (vld), rrftag=3 -> o_iss_vld=1 next cycle, o_iss_rs1=5, o_iss_rs2=7, o_iss_rrftag=3, o_iss_idx=0; i_iss_rdy=1 -> o_empty=1 after edge.
REQ-033 Dispatch rs2 invalid tag 9; two cycles later fwd channel 2 tag 9 data 0xDEAD -> o_iss_vld=1 cycle after, o_iss_rs2=0xDEAD.
REQ-034 Dispatch with rs1 tag 4 while channel 0 broadcasts tag 4 data 0x11 same cycle -> entry issuable next cycle, o_iss_rs1=0x11.
REQ-035 Dispatch DEPTH entries, i_iss_rdy=0 -> o_full=1, o_dp_rdy=0, extra dispatch ignored; one issue -> o_cnt=DEPTH-1, o_dp_rdy=1 next cycle, refill lands in freed index.
REQ-036 Entries 1 and 3 ready, 0 waiting -> o_iss_idx=1; i_flush with i_dp_vld=1 -> o_iss_vld=0, o_cnt=0 next cycle.
REQ-037 rst_n pulsed low mid-cycle with 5 entries busy -> outputs reach reset values immediately, o_cnt=0.
